dpll_phase_detector: RTL and testbench
======================================

# dpll_phase_detector

Digital phase detector and loop filter for the DPLL. It compares rising edges of an external asynchronous reference against the locally generated phased signal from the phase controller. It integrates the signed edge-to-edge error in a random-walk filter and emits single-cycle `positiveShift_o`/`negativeShift_o` pulses that close the loop back into the phase controller.

## Interface
- `SYNC_STAGES`, default 2: synchronizer depth for `referenceSignal_i`. Also the delay applied to `phasedSignal_i`.
- `ERR_WIDTH`, default 7: width of the magnitude counter.
- `HALF_PERIOD`, default 64: measurement timeout in cycles. Matches the controller's nominal half period.
- `FILTER_LIMIT`, default 4: filter threshold magnitude, at least 1.
- `LOCK_WINDOW`, default 2: maximum |error| counted as in-lock.
- `LOCK_COUNT`, default 8: consecutive in-window measurements required to assert lock.
- `clk_i` in 1: clock.
- `reset_i` in 1: reset, asynchronous, active-low.
- `referenceSignal_i` in 1: external reference, asynchronous to `clk_i`.
- `phasedSignal_i` in 1: local phased signal, synchronous to `clk_i`.
- `positiveShift_o` out 1: one-cycle pulse that delays the local phase by lengthening a half period.
- `negativeShift_o` out 1: one-cycle pulse that advances the local phase.
- `phaseError_o` out ERR_WIDTH+1: signed last measured error. Positive means local leads.
- `errorValid_o` out 1: one-cycle strobe when `phaseError_o` updates.
- `lockDetect_o` out 1: loop locked.

## Operation
- Reference passes through a SYNC_STAGES flop chain. `phasedSignal_i` passes through an equal-length delay chain so both paths have identical latency.
- Rising-edge detect on both delayed signals gives `refEdge` and `locEdge`.
- The state machine has three states: IDLE, REF_FIRST, LOC_FIRST.
- IDLE:
  - `refEdge` and `locEdge` together: error 0, measurement complete.
  - `refEdge` only: go to REF_FIRST, count=0.
  - `locEdge` only: go to LOC_FIRST, count=0.
- REF_FIRST:
  - count increments each cycle.
  - On `locEdge`: error = −(count+1), measurement complete, go to IDLE.
  - If `refEdge` and `locEdge` arrive together: `locEdge` completes the measurement first, then the state restarts as REF_FIRST with count=0.
  - Repeated `refEdge` without `locEdge`: restart count=0 and stay in REF_FIRST.
- LOC_FIRST: mirror of REF_FIRST. Error = +(count+1). Repeated `locEdge` restarts the count.
- Timeout: count reaches HALF_PERIOD−1 with no completing edge → go to IDLE. No measurement is produced and the filter is untouched. A completing edge in the same cycle takes priority over the timeout.
- The count saturates at 2^ERR_WIDTH−1 and never wraps.
- Filter:
  - Signed accumulator, range ±FILTER_LIMIT.
  - On a complete measurement: +1 if error > 0, −1 if error < 0, unchanged if error = 0.
  - Reaching +FILTER_LIMIT → pulse `positiveShift_o`, accumulator cleared to 0.
  - Reaching −FILTER_LIMIT → pulse `negativeShift_o`, accumulator cleared to 0.
  - The two shift outputs are never high together.
- Lock:
  - A measurement with |error| ≤ LOCK_WINDOW increments a saturating lock counter. Any other measurement clears the counter and deasserts `lockDetect_o`.
  - `lockDetect_o` = 1 while the counter equals LOCK_COUNT.
  - A timeout also clears the lock counter.

## Timing
- Reset values are all 0: both shift outputs, `phaseError_o`, `errorValid_o`, `lockDetect_o`, filter, counters, sync and delay chains. State is IDLE.
- A reset assertion mid-measurement aborts immediately. No pulse is emitted after release until a fresh measurement completes.
- Input edge to `refEdge`/`locEdge`: SYNC_STAGES+1 cycles. This is identical for both inputs, so relative timing is preserved.
- A completing edge registers `phaseError_o` and `errorValid_o` on the next clock.
- A shift pulse is asserted in the same cycle as the `errorValid_o` that caused the threshold crossing. It lasts exactly one cycle.
- At most one shift pulse per completed measurement.

## Structure
- Shared DPLL package holds:
  - the state enum `pd_state_t` (IDLE, REF_FIRST, LOC_FIRST);
  - the default constants HALF_PERIOD and FILTER_LIMIT, shared with the phase controller so its 0x3F terminal count derives from HALF_PERIOD.
- One sub-module, `edge_sync`, instantiated twice: N-stage delay or synchronizer plus rising-edge detect. Parameter SYNC_STAGES.
- The state machine, filter and lock logic stay in the top module.

## Test plan
- Aligned edges with equal periods, reference = local = 128-cycle period: every measurement has error 0, no shift pulses, `lockDetect_o` rises after the 8th measurement.
- Local leads by 5 cycles: `phaseError_o` = +5 and the filter steps up once per measurement. `positiveShift_o` pulses once on the 4th measurement, then the filter reads 0.
- Local lags by 3 cycles: error −3, `negativeShift_o` pulses on the 4th measurement, `lockDetect_o` stays 0.
- Reference removed, local only: each LOC_FIRST measurement times out after 64 cycles, there is no `errorValid_o`, the filter holds, and lock clears.
- Reset asserted 10 cycles into REF_FIRST while the filter is at +3: all outputs are 0 immediately. After release a +1 error produces no pulse because the filter is at 1.
- Closed loop with the phase controller and the reference offset by 20 cycles: the shift pulses drive the error toward 0 and `lockDetect_o` asserts within a bounded number of periods.

Source files
------------

// File: rtl/dpll_phase_detector_pkg.sv
// Shared DPLL definitions: phase detector state encoding and the loop
// constants that the phase detector and the phase controller must agree on.
package dpll_phase_detector_pkg;

   // Nominal half period of the locally generated signal, in clock cycles.
   // The phase controller's terminal count (0x3F) is DPLL_CTRL_TERMINAL.
   localparam int DPLL_HALF_PERIOD   = 64;
   localparam int DPLL_CTRL_TERMINAL = DPLL_HALF_PERIOD - 1;

   // Random-walk filter threshold magnitude.
   localparam int DPLL_FILTER_LIMIT  = 4;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      REF_FIRST = 2'd1,
      LOC_FIRST = 2'd2
   } pd_state_t;

   // Bits needed for a signed value spanning -limit..+limit.
   function automatic int signedWidth(input int limit);
      return $clog2(limit + 1) + 1;
   endfunction

endpackage

// File: rtl/dpll_phase_detector_if.sv
// Signal bundle between the phase detector and its environment: the two
// compared inputs, the loop-closing shift pulses and the status outputs.
interface dpll_phase_detector_if #(
   parameter int ERR_WIDTH = 7
);

   logic                   referenceSignal_i;
   logic                   phasedSignal_i;
   logic                   positiveShift_o;
   logic                   negativeShift_o;
   logic signed [ERR_WIDTH:0] phaseError_o;
   logic                   errorValid_o;
   logic                   lockDetect_o;

   // Side that drives the compared signals and consumes the results.
   modport master (
      output referenceSignal_i,
      output phasedSignal_i,
      input  positiveShift_o,
      input  negativeShift_o,
      input  phaseError_o,
      input  errorValid_o,
      input  lockDetect_o
   );

   // The phase detector itself.
   modport slave (
      input  referenceSignal_i,
      input  phasedSignal_i,
      output positiveShift_o,
      output negativeShift_o,
      output phaseError_o,
      output errorValid_o,
      output lockDetect_o
   );

endinterface

// File: rtl/dpll_phase_detector_edge_sync.sv
// N-stage flop chain followed by a registered rising-edge detector. Used as a
// metastability synchronizer for the asynchronous reference and as a matching
// delay line for the local signal, so both edges arrive with equal latency.
module edge_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic i_signal,
   output logic o_edge
);

   logic [SYNC_STAGES-1:0] r_chain;
   logic                   r_prev;
   logic                   r_edge;

   // Shift the input through the chain and flag a 0->1 transition at its end.
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         r_chain <= '0;
         r_prev  <= 1'b0;
         r_edge  <= 1'b0;
      end else begin
         r_chain <= (r_chain << 1) | SYNC_STAGES'(i_signal);
         r_prev  <= r_chain[SYNC_STAGES-1];
         r_edge  <= r_chain[SYNC_STAGES-1] & ~r_prev;
      end
   end

   assign o_edge = r_edge;

endmodule

// File: rtl/dpll_phase_detector.sv
// DPLL phase detector and loop filter. Measures the signed distance between
// reference and local rising edges, integrates its sign in a random-walk
// filter and issues single-cycle shift pulses back to the phase controller.
module dpll_phase_detector
   import dpll_phase_detector_pkg::*;
#(
   parameter int SYNC_STAGES  = 2,
   parameter int ERR_WIDTH    = 7,
   parameter int HALF_PERIOD  = DPLL_HALF_PERIOD,
   parameter int FILTER_LIMIT = DPLL_FILTER_LIMIT,
   parameter int LOCK_WINDOW  = 2,
   parameter int LOCK_COUNT   = 8
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   dpll_phase_detector_if.slave  pdIf
);

   localparam int EW1          = ERR_WIDTH + 1;
   localparam int FILTER_WIDTH = signedWidth(FILTER_LIMIT);
   localparam int LOCK_WIDTH   = $clog2(LOCK_COUNT + 1);

   localparam logic [ERR_WIDTH-1:0] COUNT_MAX     = '1;
   localparam logic [ERR_WIDTH-1:0] TIMEOUT_COUNT = ERR_WIDTH'(HALF_PERIOD - 1);
   localparam logic [ERR_WIDTH:0]   ERR_POS_MAX   = {1'b0, {ERR_WIDTH{1'b1}}};
   localparam logic [ERR_WIDTH:0]   LOCK_WIN_MAG  = EW1'(LOCK_WINDOW);

   localparam logic signed [FILTER_WIDTH-1:0] FILTER_ONE = FILTER_WIDTH'(1);
   localparam logic signed [FILTER_WIDTH-1:0] FILTER_POS = FILTER_WIDTH'(FILTER_LIMIT);
   localparam logic signed [FILTER_WIDTH-1:0] FILTER_NEG = FILTER_WIDTH'(-FILTER_LIMIT);

   localparam logic [LOCK_WIDTH-1:0] LOCK_FULL = LOCK_WIDTH'(LOCK_COUNT);

   logic w_refEdge;
   logic w_locEdge;

   pd_state_t r_state;
   pd_state_t w_nextState;

   logic [ERR_WIDTH-1:0] r_count;
   logic [ERR_WIDTH-1:0] w_countNext;

   logic w_complete;
   logic w_errPositive;
   logic w_errNegative;
   logic w_timeout;
   logic w_restart;

   logic [ERR_WIDTH:0]        w_magnitude;
   logic signed [ERR_WIDTH:0] w_errorValue;
   logic                      w_inWindow;

   logic signed [ERR_WIDTH:0] r_phaseError;
   logic                      r_errorValid;
   logic                      r_positiveShift;
   logic                      r_negativeShift;

   logic signed [FILTER_WIDTH-1:0] r_filter;
   logic signed [FILTER_WIDTH-1:0] w_filterNext;
   logic                           w_posShift;
   logic                           w_negShift;

   logic [LOCK_WIDTH-1:0] r_lockCount;
   logic [LOCK_WIDTH-1:0] w_lockNext;

   edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_refSync (
      .clk_i    (clk_i),
      .reset_i  (reset_i),
      .i_signal (pdIf.referenceSignal_i),
      .o_edge   (w_refEdge)
   );

   edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_locDelay (
      .clk_i    (clk_i),
      .reset_i  (reset_i),
      .i_signal (pdIf.phasedSignal_i),
      .o_edge   (w_locEdge)
   );

   // Measurement state register.
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Which edge opened the current measurement; a repeat of the opening edge restarts it.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE: begin
            if (w_refEdge && w_locEdge) begin
               w_nextState = IDLE;
            end else if (w_refEdge) begin
               w_nextState = REF_FIRST;
            end else if (w_locEdge) begin
               w_nextState = LOC_FIRST;
            end
         end
         REF_FIRST: begin
            if (w_refEdge) begin
               w_nextState = REF_FIRST;
            end else if (w_locEdge || (r_count == TIMEOUT_COUNT)) begin
               w_nextState = IDLE;
            end
         end
         LOC_FIRST: begin
            if (w_locEdge) begin
               w_nextState = LOC_FIRST;
            end else if (w_refEdge || (r_count == TIMEOUT_COUNT)) begin
               w_nextState = IDLE;
            end
         end
         default: w_nextState = IDLE;
      endcase
   end

   // Measurement events: completion with its sign, timeout, restart and the next count.
   always_comb begin
      w_complete    = 1'b0;
      w_errPositive = 1'b0;
      w_errNegative = 1'b0;
      w_timeout     = 1'b0;
      w_restart     = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_refEdge && w_locEdge) begin
               w_complete = 1'b1;
            end
         end
         REF_FIRST: begin
            if (w_locEdge) begin
               w_complete    = 1'b1;
               w_errNegative = 1'b1;
            end
            if (w_refEdge) begin
               w_restart = 1'b1;
            end else if (!w_locEdge && (r_count == TIMEOUT_COUNT)) begin
               w_timeout = 1'b1;
            end
         end
         LOC_FIRST: begin
            if (w_refEdge) begin
               w_complete    = 1'b1;
               w_errPositive = 1'b1;
            end
            if (w_locEdge) begin
               w_restart = 1'b1;
            end else if (!w_refEdge && (r_count == TIMEOUT_COUNT)) begin
               w_timeout = 1'b1;
            end
         end
         default: ;
      endcase

      if ((r_state == IDLE) || w_restart || (w_nextState == IDLE)) begin
         w_countNext = '0;
      end else if (r_count == COUNT_MAX) begin
         w_countNext = r_count;
      end else begin
         w_countNext = r_count + 1'b1;
      end
   end

   // Edge-to-edge distance; a positive value too large for the output clamps to its maximum.
   assign w_magnitude = {1'b0, r_count} + EW1'(1);

   // Signed error of a completing measurement and its in-window test.
   always_comb begin
      w_errorValue = '0;
      if (w_errPositive) begin
         w_errorValue = w_magnitude[ERR_WIDTH] ? ERR_POS_MAX : w_magnitude;
      end else if (w_errNegative) begin
         w_errorValue = -w_magnitude;
      end
      w_inWindow = !(w_errPositive || w_errNegative) || (w_magnitude <= LOCK_WIN_MAG);
   end

   // Random-walk filter: step by the error sign, fire a shift and clear at either threshold.
   always_comb begin
      w_filterNext = r_filter;
      w_posShift   = 1'b0;
      w_negShift   = 1'b0;
      if (w_complete) begin
         if (w_errPositive) begin
            w_filterNext = r_filter + FILTER_ONE;
         end else if (w_errNegative) begin
            w_filterNext = r_filter - FILTER_ONE;
         end
         if (w_filterNext == FILTER_POS) begin
            w_posShift   = 1'b1;
            w_filterNext = '0;
         end else if (w_filterNext == FILTER_NEG) begin
            w_negShift   = 1'b1;
            w_filterNext = '0;
         end
      end
   end

   // Lock counter: consecutive small errors count up, anything else or a timeout clears it.
   always_comb begin
      w_lockNext = r_lockCount;
      if (w_timeout) begin
         w_lockNext = '0;
      end else if (w_complete) begin
         if (!w_inWindow) begin
            w_lockNext = '0;
         end else if (r_lockCount != LOCK_FULL) begin
            w_lockNext = r_lockCount + 1'b1;
         end
      end
   end

   // Counter, filter, lock and registered outputs, all updated from the comb results.
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         r_count         <= '0;
         r_phaseError    <= '0;
         r_errorValid    <= 1'b0;
         r_positiveShift <= 1'b0;
         r_negativeShift <= 1'b0;
         r_filter        <= '0;
         r_lockCount     <= '0;
      end else begin
         r_count         <= w_countNext;
         r_errorValid    <= w_complete;
         if (w_complete) begin
            r_phaseError <= w_errorValue;
         end
         r_positiveShift <= w_posShift;
         r_negativeShift <= w_negShift;
         r_filter        <= w_filterNext;
         r_lockCount     <= w_lockNext;
      end
   end

   assign pdIf.phaseError_o    = r_phaseError;
   assign pdIf.errorValid_o    = r_errorValid;
   assign pdIf.positiveShift_o = r_positiveShift;
   assign pdIf.negativeShift_o = r_negativeShift;
   assign pdIf.lockDetect_o    = (r_lockCount == LOCK_FULL);

endmodule

// File: tb/tb_dpll_phase_detector.sv
// Directed bench for the DPLL phase detector: drives 128-cycle periods of
// reference and local signals with chosen rising-edge positions and checks the
// per-period measurement, shift pulses and lock against hand-computed values.
module tb_dpll_phase_detector;

   logic clk_i   = 1'b0;
   logic reset_i = 1'b0;

   int vectors     = 0;
   int miscompares = 0;

   int pVal;
   int pErr;
   int pPos;
   int pNeg;
   int pStray;

   dpll_phase_detector_if #(.ERR_WIDTH(7)) pdIf ();

   dpll_phase_detector dut (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .pdIf    (pdIf)
   );

   always #5 clk_i = ~clk_i;

   // Advance one clock; leaves the bench 1 time unit past the rising edge.
   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic checkOutput(input string tag, input int observed, input int expected);
      vectors++;
      assert (observed === expected)
      else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
      end
   endtask

   // Collect per-cycle observations into the period counters.
   task automatic sampleOutputs();
      if (pdIf.errorValid_o) begin
         pVal++;
         pErr = int'($signed(pdIf.phaseError_o));
      end
      if (pdIf.positiveShift_o) pPos++;
      if (pdIf.negativeShift_o) pNeg++;
      if (((pdIf.positiveShift_o || pdIf.negativeShift_o) && !pdIf.errorValid_o) ||
          (pdIf.positiveShift_o && pdIf.negativeShift_o)) pStray++;
   endtask

   // One 128-cycle period; each enabled signal is high for 64 cycles from its edge position.
   task automatic applyStimulus(input bit locOn, input int locPos, input bit refOn, input int refPos);
      pVal = 0; pErr = 0; pPos = 0; pNeg = 0; pStray = 0;
      for (int c = 0; c < 128; c++) begin
         pdIf.phasedSignal_i    = locOn && (c >= locPos) && (c < locPos + 64);
         pdIf.referenceSignal_i = refOn && (c >= refPos) && (c < refPos + 64);
         tick();
         sampleOutputs();
      end
   endtask

   task automatic checkPeriod(input string tag, input int expVal, input int expErr,
                              input int expPos, input int expNeg, input int expLock);
      checkOutput({tag, " validCount"}, pVal, expVal);
      if (expVal > 0) checkOutput({tag, " phaseError"}, pErr, expErr);
      checkOutput({tag, " posShifts"}, pPos, expPos);
      checkOutput({tag, " negShifts"}, pNeg, expNeg);
      checkOutput({tag, " lockDetect"}, int'(pdIf.lockDetect_o), expLock);
      checkOutput({tag, " strayShift"}, pStray, 0);
   endtask

   initial begin
      pdIf.referenceSignal_i = 1'b0;
      pdIf.phasedSignal_i    = 1'b0;

      // Reset state.
      repeat (3) tick();
      checkOutput("reset phaseError", int'($signed(pdIf.phaseError_o)), 0);
      checkOutput("reset errorValid", int'(pdIf.errorValid_o), 0);
      checkOutput("reset posShift", int'(pdIf.positiveShift_o), 0);
      checkOutput("reset negShift", int'(pdIf.negativeShift_o), 0);
      checkOutput("reset lock", int'(pdIf.lockDetect_o), 0);
      reset_i = 1'b1;
      repeat (5) tick();

      // Aligned edges: zero error, lock after the 8th measurement.
      for (int i = 1; i <= 8; i++) begin
         applyStimulus(1'b1, 10, 1'b1, 10);
         checkPeriod($sformatf("aligned%0d", i), 1, 0, 0, 0, (i == 8) ? 1 : 0);
      end

      // Reference removed: local-first measurements time out, lock clears.
      for (int i = 1; i <= 2; i++) begin
         applyStimulus(1'b1, 10, 1'b0, 0);
         checkPeriod($sformatf("noRef%0d", i), 0, 0, 0, 0, 0);
      end

      // Local leads by 5: filter untouched by timeouts, pulse on 4th.
      for (int i = 1; i <= 4; i++) begin
         applyStimulus(1'b1, 10, 1'b1, 15);
         checkPeriod($sformatf("lead5_%0d", i), 1, 5, (i == 4) ? 1 : 0, 0, 0);
      end

      // Local lags by 3: negative pulse on 4th.
      for (int i = 1; i <= 4; i++) begin
         applyStimulus(1'b1, 13, 1'b1, 10);
         checkPeriod($sformatf("lag3_%0d", i), 1, -3, 0, (i == 4) ? 1 : 0, 0);
      end

      // Bring the filter to +3, then reset in the middle of a reference-first measurement.
      for (int i = 1; i <= 3; i++) begin
         applyStimulus(1'b1, 10, 1'b1, 15);
         checkPeriod($sformatf("preReset%0d", i), 1, 5, 0, 0, 0);
      end
      pdIf.phasedSignal_i    = 1'b0;
      pdIf.referenceSignal_i = 1'b1;
      repeat (14) tick();
      reset_i = 1'b0;
      #1;
      checkOutput("midReset phaseError", int'($signed(pdIf.phaseError_o)), 0);
      checkOutput("midReset errorValid", int'(pdIf.errorValid_o), 0);
      checkOutput("midReset posShift", int'(pdIf.positiveShift_o), 0);
      checkOutput("midReset negShift", int'(pdIf.negativeShift_o), 0);
      pdIf.referenceSignal_i = 1'b0;
      repeat (3) tick();
      reset_i = 1'b1;
      pVal = 0; pErr = 0; pPos = 0; pNeg = 0; pStray = 0;
      for (int c = 0; c < 20; c++) begin
         tick();
         sampleOutputs();
      end
      checkOutput("postReset validCount", pVal, 0);
      checkOutput("postReset shifts", pPos + pNeg, 0);

      // Lead by 1 after reset: filter restarted at 0, so pulse only on the 4th.
      for (int i = 1; i <= 4; i++) begin
         applyStimulus(1'b1, 10, 1'b1, 11);
         checkPeriod($sformatf("lead1_%0d", i), 1, 1, (i == 4) ? 1 : 0, 0, 0);
      end

      // Timeout boundary: 64 cycles still measures, 65 times out.
      applyStimulus(1'b1, 10, 1'b1, 74);
      checkPeriod("lead64", 1, 64, 0, 0, 0);
      applyStimulus(1'b1, 10, 1'b1, 75);
      checkPeriod("lead65", 0, 0, 0, 0, 0);
      applyStimulus(1'b0, 0, 1'b0, 0);
      checkPeriod("quiet", 0, 0, 0, 0, 0);
      applyStimulus(1'b1, 74, 1'b1, 10);
      checkPeriod("lag64", 1, -64, 0, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
